// File: rtl/sync_deserializer.sv
// Serial-to-parallel consumer: samples q_i on each sync strobe, packs WIDTH bits LSB-first
// into a single-entry valid/ready holding register, and flags lost sync and overrun.
// Optional feature macro: SYNC_PERIOD_CHECK_EN (strobe spacing check, adds period_err_o).
module sync_deserializer #(
  parameter int  WIDTH       = 8,
  parameter int  SYNC_PERIOD = 3,
  parameter int  TIMEOUT     = 8,
  localparam int BCW         = $clog2(WIDTH + 1),
  localparam int GCW         = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             q_i,
  input  logic             sync_i,
  output logic [WIDTH-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i,
  output logic [BCW-1:0]   bit_count_o,
  output logic             lost_sync_o,
  output logic             overrun_o,
`ifdef SYNC_PERIOD_CHECK_EN
  output logic             period_err_o,
`endif
  input  logic             clear_i
);

  typedef enum logic {HUNT, COLLECT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [BCW-1:0]   bc_q, bc_d;
  logic [GCW-1:0]   gap_q, gap_d;
  logic             vld_q, vld_d;
  logic             lost_q, lost_d;
  logic             ovr_q, ovr_d;
  logic             done;
`ifdef SYNC_PERIOD_CHECK_EN
  logic             perr_q, perr_d;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= HUNT;
      sr_q    <= '0;
      word_q  <= '0;
      bc_q    <= '0;
      gap_q   <= '0;
      vld_q   <= 1'b0;
      lost_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SYNC_PERIOD_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      word_q  <= word_d;
      bc_q    <= bc_d;
      gap_q   <= gap_d;
      vld_q   <= vld_d;
      lost_q  <= lost_d;
      ovr_q   <= ovr_d;
`ifdef SYNC_PERIOD_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    word_d  = word_q;
    bc_d    = bc_q;
    gap_d   = gap_q;
    vld_d   = vld_q;
    lost_d  = 1'b0;
    ovr_d   = ovr_q;
    done    = 1'b0;
`ifdef SYNC_PERIOD_CHECK_EN
    perr_d  = perr_q;
    if (clear_i) perr_d = 1'b0;
`endif
    if (clear_i) ovr_d = 1'b0;
    if (vld_q && word_ready_i) vld_d = 1'b0;

    case (state_q)
      HUNT: begin
        gap_d = '0;
        if (sync_i) begin
          sr_d[0] = q_i;
          bc_d    = BCW'(1);
          state_d = COLLECT;
        end
      end
      default: begin
        if (sync_i) begin
          gap_d = '0;
          for (int i = 0; i < WIDTH; i++)
            if (bc_q == BCW'(i)) sr_d[i] = q_i;
          if (bc_q == BCW'(WIDTH - 1)) begin
            done = 1'b1;
            bc_d = '0;
          end else begin
            bc_d = bc_q + BCW'(1);
          end
`ifdef SYNC_PERIOD_CHECK_EN
          // Off-period strobe restarts the word with this sample as bit 0.
          if (gap_q != GCW'(SYNC_PERIOD - 1)) begin
            done    = 1'b0;
            sr_d[0] = q_i;
            bc_d    = BCW'(1);
            perr_d  = 1'b1;
          end
`endif
        end else if (gap_q == GCW'(TIMEOUT - 1)) begin
          gap_d   = GCW'(TIMEOUT);
          bc_d    = '0;
          lost_d  = 1'b1;
          state_d = HUNT;
        end else if (gap_q != GCW'(TIMEOUT)) begin
          gap_d = gap_q + GCW'(1);
        end
      end
    endcase

    // A same-cycle consume frees the holding register for the completing word.
    if (done) begin
      if (!vld_q || word_ready_i) begin
        word_d = sr_d;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = vld_q;
  assign bit_count_o  = bc_q;
  assign lost_sync_o  = lost_q;
  assign overrun_o    = ovr_q;
`ifdef SYNC_PERIOD_CHECK_EN
  assign period_err_o = perr_q;
`endif

endmodule

// File: tb/tb_sync_deserializer.sv
// Bench for sync_deserializer: directed scenarios plus randomized strobes, checked against
// a queue-based reference model of the word assembly and handshake rules.
module tb_sync_deserializer;
  localparam int WIDTH       = 8;
  localparam int SYNC_PERIOD = 3;
  localparam int TIMEOUT     = 8;
  localparam int BCW         = $clog2(WIDTH + 1);
`ifdef SYNC_PERIOD_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b0;
  logic             q_i = 1'b0;
  logic             sync_i = 1'b0;
  logic             word_ready_i = 1'b0;
  logic             clear_i = 1'b0;
  logic [WIDTH-1:0] word_o;
  logic             word_valid_o;
  logic [BCW-1:0]   bit_count_o;
  logic             lost_sync_o;
  logic             overrun_o;
`ifdef SYNC_PERIOD_CHECK_EN
  logic             period_err_o;
`endif

  sync_deserializer #(.WIDTH(WIDTH), .SYNC_PERIOD(SYNC_PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .q_i          (q_i),
    .sync_i       (sync_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .bit_count_o  (bit_count_o),
    .lost_sync_o  (lost_sync_o),
    .overrun_o    (overrun_o),
`ifdef SYNC_PERIOD_CHECK_EN
    .period_err_o (period_err_o),
`endif
    .clear_i      (clear_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit             m_bits[$];
  bit             m_hunt = 1'b1;
  int             m_cyc = 0;
  int             m_last = 0;
  logic [WIDTH-1:0] m_word = '0;
  bit             m_valid = 1'b0;
  bit             m_ovr = 1'b0;
  bit             m_lost = 1'b0;
  bit             m_perr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("word", 32'(word_o), 32'(m_word));
    chk("word_valid", 32'(word_valid_o), 32'(m_valid));
    chk("bit_count", 32'(bit_count_o), m_bits.size());
    chk("lost_sync", 32'(lost_sync_o), 32'(m_lost));
    chk("overrun", 32'(overrun_o), 32'(m_ovr));
`ifdef SYNC_PERIOD_CHECK_EN
    chk("period_err", 32'(period_err_o), 32'(m_perr));
`endif
  endtask

  task automatic model_step(input bit q, input bit s, input bit r, input bit c);
    int gap;
    m_lost = 1'b0;
    if (m_valid && r) m_valid = 1'b0;
    if (c) begin
      m_ovr  = 1'b0;
      m_perr = 1'b0;
    end
    if (m_hunt) begin
      if (s) begin
        m_bits.delete();
        m_bits.push_back(q);
        m_hunt = 1'b0;
        m_last = m_cyc;
      end
    end else if (s) begin
      gap    = m_cyc - m_last;
      m_last = m_cyc;
      if (PCHK && gap != SYNC_PERIOD) begin
        m_perr = 1'b1;
        m_bits.delete();
        m_bits.push_back(q);
      end else begin
        m_bits.push_back(q);
        if (m_bits.size() == WIDTH) begin
          if (!m_valid) begin
            for (int i = 0; i < WIDTH; i++) m_word[i] = m_bits[i];
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
          m_bits.delete();
        end
      end
    end else if (m_cyc - m_last >= TIMEOUT) begin
      m_hunt = 1'b1;
      m_bits.delete();
      m_lost = 1'b1;
    end
    m_cyc++;
  endtask

  task automatic step(input bit q, input bit s, input bit r, input bit c);
    @(negedge clk_i);
    reset_i = 1'b1; q_i = q; sync_i = s; word_ready_i = r; clear_i = c;
    model_step(q, s, r, c);
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b0; q_i = 1'($urandom); sync_i = 1'($urandom);
    word_ready_i = 1'($urandom); clear_i = 1'b0;
    m_bits.delete();
    m_hunt = 1'b1; m_word = '0; m_valid = 1'b0;
    m_ovr = 1'b0; m_lost = 1'b0; m_perr = 1'b0;
    m_cyc++;
    @(posedge clk_i);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit r);
    repeat (n) step(1'($urandom), 1'b0, r, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] pat;
    int since, hold;
    bit s;

    do_reset();
    do_reset();
    chk("reset_valid", 32'(word_valid_o), 0);
    chk("reset_bc", 32'(bit_count_o), 0);

    // 1: alternating bits -> 8'h55
    for (int i = 0; i < WIDTH; i++) begin
      step(~i[0], 1'b1, 1'b0, 1'b0);
      if (i == WIDTH - 2) chk("t1_not_yet_valid", 32'(word_valid_o), 0);
      if (i < WIDTH - 1) idle(2, 1'b0);
    end
    chk("t1_word", 32'(word_o), 32'h55);
    chk("t1_valid", 32'(word_valid_o), 1);
    chk("t1_bc", 32'(bit_count_o), 0);
    idle(2, 1'b1);
    chk("t1_consumed", 32'(word_valid_o), 0);

    // 2: ready held low across two full words -> overrun, then clear
    for (int i = 0; i < 2 * WIDTH; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (i < 2 * WIDTH - 1) idle(2, 1'b0);
    end
    chk("t2_word", 32'(word_o), 32'hFF);
    chk("t2_valid", 32'(word_valid_o), 1);
    chk("t2_overrun", 32'(overrun_o), 1);
    step(1'($urandom), 1'b0, 1'b0, 1'b1);
    chk("t2_cleared", 32'(overrun_o), 0);
    idle(1, 1'b0);

    // 4: consume on the exact completion cycle of the next word
    pat = 8'hA3;
    for (int i = 0; i < WIDTH; i++) begin
      step(pat[i], 1'b1, (i == WIDTH - 1), 1'b0);
      if (i < WIDTH - 1) idle(2, 1'b0);
    end
    chk("t4_word", 32'(word_o), 32'hA3);
    chk("t4_valid", 32'(word_valid_o), 1);
    chk("t4_overrun", 32'(overrun_o), 0);
    idle(2, 1'b0);

    // 3: four strobes then silence -> lost_sync
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);
    end
    idle(TIMEOUT - 3, 1'b0);
    chk("t3_lost_early", 32'(lost_sync_o), 0);
    idle(1, 1'b0);
    chk("t3_lost", 32'(lost_sync_o), 1);
    chk("t3_bc", 32'(bit_count_o), 0);
    chk("t3_hold_kept", 32'(word_o), 32'hA3);
    idle(1, 1'b1);
    chk("t3_lost_pulse", 32'(lost_sync_o), 0);
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);
    end
    chk("t3_word", 32'(word_o), 32'h00);
    chk("t3_valid", 32'(word_valid_o), 1);

    // 5: reset mid-word with a pending word
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2, 1'b0);
    end
    do_reset();
    chk("t5_valid", 32'(word_valid_o), 0);
    chk("t5_bc", 32'(bit_count_o), 0);
    chk("t5_word", 32'(word_o), 0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_hunt_ignores_q", 32'(bit_count_o), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_first_bit", 32'(bit_count_o), 1);

`ifdef SYNC_PERIOD_CHECK_EN
    // 6: gaps 3,3,2 -> period_err, restart at bit 0
    idle(2, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_no_err", 32'(period_err_o), 0);
    idle(1, 1'b0); step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_period_err", 32'(period_err_o), 1);
    chk("t6_bc", 32'(bit_count_o), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_clear", 32'(period_err_o), 0);
`endif

    // Randomized strobes: mostly on-period, with jitter, long gaps and sporadic resets
    since = 0;
    hold = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        continue;
      end
      if (hold == 0 && $urandom_range(0, 79) == 0) hold = TIMEOUT + 2;
      if (hold > 0) begin
        s = 1'b0;
        hold--;
      end else if (since >= SYNC_PERIOD - 1) begin
        s = ($urandom_range(0, 15) != 0);
      end else begin
        s = ($urandom_range(0, 15) == 0);
      end
      since = s ? 0 : since + 1;
      step(1'($urandom), s, 1'($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
